// File: rtl/alu_execute_stage.sv
// Registered ALU execute stage: result, flags and branch decision one cycle after accept.
// Valid/ready with a main+skid pair, so a downstream stall never drops or duplicates an op.
module alu_execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       alu_control,
  input  logic             z,
  input  logic             g,
  input  logic [4:0]       rd_in,
  input  logic             reg_write_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             branch_taken,
  output logic [4:0]       rd_out,
  output logic             reg_write_out
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             branch_taken;
    logic [4:0]       rd;
    logic             reg_write;
  } payload_t;

  payload_t   pl_new;
  payload_t   main_q, main_d;
  payload_t   skid_q, skid_d;
  logic       main_vld_q, main_vld_d;
  logic       skid_vld_q, skid_vld_d;
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic       lt_signed;
  logic       accept;
  logic       main_held;

  // Subtraction as A + ~B + 1 so the carry-out directly means "no borrow" (A >= B unsigned).
  assign sum_ext   = {1'b0, src_a} + {1'b0, src_b};
  assign diff_ext  = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
  assign lt_signed = $signed(src_a) < $signed(src_b);

  always_comb begin
    pl_new           = '0;
    pl_new.result    = sum_ext[WIDTH-1:0];
    pl_new.carry     = sum_ext[WIDTH];
    pl_new.overflow  = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                       (sum_ext[WIDTH-1] != src_a[WIDTH-1]);
    case (alu_control)
      3'b001: begin
        pl_new.result   = diff_ext[WIDTH-1:0];
        pl_new.carry    = diff_ext[WIDTH];
        pl_new.overflow = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != src_a[WIDTH-1]);
      end
      3'b010: begin
        pl_new.result   = src_a & src_b;
        pl_new.carry    = 1'b0;
        pl_new.overflow = 1'b0;
      end
      3'b011: begin
        pl_new.result   = src_a | src_b;
        pl_new.carry    = 1'b0;
        pl_new.overflow = 1'b0;
      end
      3'b100: begin
        pl_new.result   = src_a ^ src_b;
        pl_new.carry    = 1'b0;
        pl_new.overflow = 1'b0;
      end
      3'b101: begin
        pl_new.result   = {{(WIDTH-1){1'b0}}, lt_signed};
        pl_new.carry    = 1'b0;
        pl_new.overflow = 1'b0;
      end
      default: ;
    endcase
    pl_new.zero         = (pl_new.result == '0);
    pl_new.negative     = pl_new.result[WIDTH-1];
    // Branch decision depends only on operands; beq wins over bge.
    pl_new.branch_taken = z ? (src_a == src_b) : (g ? !lt_signed : 1'b0);
    pl_new.rd           = rd_in;
    pl_new.reg_write    = reg_write_in;
  end

  // in_ready is exactly the registered "skid empty" bit.
  assign in_ready  = !skid_vld_q;
  assign accept    = in_valid && in_ready;
  assign main_held = main_vld_q && !out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (main_held) begin
      if (accept) begin
        skid_d     = pl_new;
        skid_vld_d = 1'b1;
      end
    end else if (skid_vld_q) begin
      main_d     = skid_q;
      main_vld_d = 1'b1;
      skid_vld_d = 1'b0;
    end else begin
      main_vld_d = accept;
      if (accept) begin
        main_d = pl_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid     = main_vld_q;
  assign result        = main_q.result;
  assign zero          = main_q.zero;
  assign negative      = main_q.negative;
  assign carry         = main_q.carry;
  assign overflow      = main_q.overflow;
  assign branch_taken  = main_q.branch_taken;
  assign rd_out        = main_q.rd;
  assign reg_write_out = main_q.reg_write;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Bench for alu_execute_stage: directed scenarios plus a random stream checked
// against a 2-deep queue model fed by an arithmetic reference function.
module tb_alu_execute_stage;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        branch_taken;
    logic [4:0]  rd;
    logic        rw;
  } pl_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  alu_control;
  logic        z;
  logic        g;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;
  logic        branch_taken;
  logic [4:0]  rd_out;
  logic        reg_write_out;

  pl_t obs;
  pl_t mq[$];
  int  checks = 0;
  int  passed = 0;

  always #5 clk = ~clk;

  alu_execute_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .alu_control(alu_control),
    .z(z), .g(g), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .branch_taken(branch_taken),
    .rd_out(rd_out), .reg_write_out(reg_write_out)
  );

  assign obs = {result, zero, negative, carry, overflow, branch_taken, rd_out, reg_write_out};

  function automatic pl_t ref_calc(logic [31:0] a, logic [31:0] b, logic [2:0] op,
                                   logic zf, logic gf, logic [4:0] rd, logic rw);
    pl_t    p;
    longint ua, ub, sa, sb, r;
    p  = '0;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin
        r = ua - ub;
        p.carry = (ua >= ub);
        p.overflow = (sa - sb > SMAX) || (sa - sb < SMIN);
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sb) ? 64'd1 : 64'd0;
      default: begin
        r = ua + ub;
        p.carry = (r >= 64'h1_0000_0000);
        p.overflow = (sa + sb > SMAX) || (sa + sb < SMIN);
      end
    endcase
    p.result = r[31:0];
    p.zero = (p.result == 32'd0);
    p.negative = p.result[31];
    p.branch_taken = zf ? (a == b) : (gf ? (sa >= sb) : 1'b0);
    p.rd = rd;
    p.rw = rw;
    return p;
  endfunction

  task automatic drive(logic v, logic [31:0] a, logic [31:0] b, logic [2:0] op,
                       logic zf, logic gf, logic [4:0] rd, logic rw);
    in_valid = v;
    src_a = a;
    src_b = b;
    alu_control = op;
    z = zf;
    g = gf;
    rd_in = rd;
    reg_write_in = rw;
  endtask

  // Advance one clock, updating the queue model from the inputs seen at the edge.
  task automatic tick();
    bit acc, drn;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
    end else begin
      acc = in_valid && (mq.size() < 2);
      drn = (mq.size() > 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(ref_calc(src_a, src_b, alu_control, z, g, rd_in, reg_write_in));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'd7, 32'd9, 3'd0, 1'b0, 1'b0, 5'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
      else passed++;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
      else passed++;
      checks++;
      if (obs !== '0) $display("FAIL reset_payload: got %h want 0", obs);
      else passed++;
    end
    rst = 1'b1;
    drive(1'b1, 32'd10, 32'd20, 3'd0, 1'b0, 1'b0, 5'd4, 1'b1);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_release_early: got %b want 0", out_valid);
    else passed++;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd30 || rd_out !== 5'd4)
      $display("FAIL reset_first_op: got vld=%b res=%h rd=%0d want 1/0000001e/4", out_valid, result, rd_out);
    else passed++;
    tick();
  endtask

  task automatic test_arith();
    logic [31:0] va [9] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h0000F0F0,
                            32'h0000000A, 32'd7, 32'd2, 32'h80000000};
    logic [31:0] vb [9] = '{32'd1, 32'd1, 32'd7, 32'd1, 32'h0000FF00,
                            32'h0000000A, 32'd5, 32'd3, 32'd1};
    logic [2:0]  vo [9] = '{3'd0, 3'd0, 3'd1, 3'd5, 3'd2, 3'd4, 3'd1, 3'd7, 3'd1};
    logic [31:0] er [9] = '{32'd0, 32'h80000000, 32'hFFFFFFFE, 32'd1, 32'h0000F000,
                            32'd0, 32'd2, 32'd5, 32'h7FFFFFFF};
    logic [3:0]  ef [9] = '{4'b1010, 4'b0101, 4'b0100, 4'b0000, 4'b0000,
                            4'b1000, 4'b0010, 4'b0000, 4'b0011};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, va[i], vb[i], vo[i], 1'b0, 1'b0, 5'(i), 1'b1);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== er[i])
        $display("FAIL arith_result[%0d]: got vld=%b res=%h want 1/%h", i, out_valid, result, er[i]);
      else passed++;
      checks++;
      if ({zero, negative, carry, overflow} !== ef[i])
        $display("FAIL arith_flags[%0d]: got znco=%b want %b", i, {zero, negative, carry, overflow}, ef[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_branch();
    logic        bz [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        bg [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ba [7] = '{32'h1234, 32'hFFFFFFFD, 32'd2, 32'd1, 32'd5, 32'd5, 32'd7};
    logic [31:0] bb [7] = '{32'h1234, 32'd2, 32'hFFFFFFFD, 32'd0, 32'd5, 32'd6, 32'd7};
    logic        bt [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ba[i], bb[i], 3'd2, bz[i], bg[i], 5'd1, 1'b0);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || branch_taken !== bt[i])
        $display("FAIL branch[%0d]: got vld=%b taken=%b want 1/%b", i, out_valid, branch_taken, bt[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    pl_t got[$];
    pl_t op1;
    int  next = 1;
    op1 = ref_calc(32'd1, 32'd0, 3'd0, 1'b0, 1'b0, 5'd1, 1'b1);
    for (int c = 1; c <= 20 && got.size() < 6; c++) begin
      checks++;
      if (in_ready !== (mq.size() < 2))
        $display("FAIL b2b_in_ready[c%0d]: got %b want %b", c, in_ready, mq.size() < 2);
      else passed++;
      if (c == 3) begin
        checks++;
        if (in_ready !== 1'b0) $display("FAIL b2b_ready_drop: got %b want 0", in_ready);
        else passed++;
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== op1)
          $display("FAIL b2b_hold[c%0d]: got vld=%b pl=%h want 1/%h", c, out_valid, obs, op1);
        else passed++;
      end
      out_ready = !(c >= 2 && c <= 4);
      if (next <= 6) drive(1'b1, 32'(next), 32'd0, 3'd0, 1'b0, 1'b0, 5'(next), 1'b1);
      else in_valid = 1'b0;
      if (out_valid && out_ready) got.push_back(obs);
      if (in_valid && mq.size() < 2) next++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 6) $display("FAIL b2b_count: got %0d want 6", got.size());
    else passed++;
    for (int k = 0; k < got.size() && k < 6; k++) begin
      checks++;
      if (got[k] !== ref_calc(32'(k + 1), 32'd0, 3'd0, 1'b0, 1'b0, 5'(k + 1), 1'b1))
        $display("FAIL b2b_order[%0d]: got res=%h want %0d", k, got[k].result, k + 1);
      else passed++;
    end
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'd100, 32'd0, 3'd0, 1'b0, 1'b0, 5'd1, 1'b1);
    tick();
    drive(1'b1, 32'd200, 32'd0, 3'd0, 1'b0, 1'b0, 5'd2, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL flush_full: got vld=%b rdy=%b want 1/0", out_valid, in_ready);
    else passed++;
    drive(1'b1, 32'd300, 32'd0, 3'd0, 1'b0, 1'b0, 5'd3, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_clear: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
    else passed++;
    out_ready = 1'b1;
    drive(1'b1, 32'd400, 32'd0, 3'd0, 1'b0, 1'b0, 5'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd400)
      $display("FAIL flush_next_op: got vld=%b res=%0d want 1/400", out_valid, result);
    else passed++;
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_no_ghost: got vld=%b want 0", out_valid);
    else passed++;
    // Flush in a cycle where the stage would otherwise accept into skid.
    out_ready = 1'b0;
    drive(1'b1, 32'd500, 32'd0, 3'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    tick();
    drive(1'b1, 32'd600, 32'd0, 3'd0, 1'b0, 1'b0, 5'd6, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_over_accept: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
    else passed++;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0;
    drive(1'b1, 32'd11, 32'd0, 3'd0, 1'b0, 1'b0, 5'd1, 1'b1);
    tick();
    drive(1'b1, 32'd22, 32'd0, 3'd0, 1'b0, 1'b0, 5'd2, 1'b1);
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0)
      $display("FAIL midstall_reset: got vld=%b rdy=%b res=%h want 0/1/0", out_valid, in_ready, result);
    else passed++;
    mq.delete();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL midstall_after: got vld=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 10000; n++) begin
      checks++;
      if (out_valid !== (mq.size() > 0))
        $display("FAIL rand_out_valid[%0d]: got %b want %b", n, out_valid, mq.size() > 0);
      else passed++;
      checks++;
      if (in_ready !== (mq.size() < 2))
        $display("FAIL rand_in_ready[%0d]: got %b want %b", n, in_ready, mq.size() < 2);
      else passed++;
      if (mq.size() > 0) begin
        checks++;
        if (obs !== mq[0]) $display("FAIL rand_payload[%0d]: got %h want %h", n, obs, mq[0]);
        else passed++;
      end
      a = $urandom;
      drive(($urandom_range(0, 3) != 0), a,
            ($urandom_range(0, 7) == 0) ? a : 32'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
            5'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    test_reset();
    test_arith();
    test_branch();
    test_back_to_back();
    test_flush();
    test_reset_midstall();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_execute_stage.md
# alu_execute_stage

Registered execute stage that sits directly downstream of the ALU control decoder. It consumes the 3-bit ALU control code and the branch-type flags (z for beq, g for bge), computes the ALU result, status flags and branch decision, and registers them. The block has a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never drops or duplicates an operation.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits; all arithmetic rules below use WIDTH=32.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  upstream operation present.
- in_ready  out  1  stage can accept; registered.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- alu_control  in  3  operation code: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110/111 add.
- z  in  1  beq branch-type flag.
- g  in  1  bge branch-type flag.
- rd_in  in  5  destination register index.
- reg_write_in  in  1  write-enable to carry through.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- result  out  WIDTH  ALU result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  add: carry-out; sub: 1 when A>=B unsigned (no borrow); otherwise 0.
- overflow  out  1  signed overflow for add/sub; otherwise 0.
- branch_taken  out  1  branch decision.
- rd_out  out  5  registered rd_in.
- reg_write_out  out  1  registered reg_write_in.

## Operation
- Accept when in_valid && in_ready. Emit when out_valid && out_ready.
- add: A+B mod 2^32. sub: A+~B+1 mod 2^32. and/or/xor: bitwise. slt: {31'b0, signed(A)<signed(B)}.
- Overflow: add gives (A[31]==B[31]) && (R[31]!=A[31]). sub gives (A[31]!=B[31]) && (R[31]!=A[31]).
- branch_taken is computed from the operands, independent of alu_control:
  - z=1: taken when A==B.
  - z=0, g=1: taken when signed(A)>=signed(B).
  - Neither set: 0.
  - z has priority when both are set.
- Payload = {result, zero, negative, carry, overflow, branch_taken, rd, reg_write}. All of it is computed combinationally from the inputs and captured at acceptance.
- Storage is a main register (drives the outputs) plus a skid register.
  - Accept while main is empty or draining: the payload goes to main.
  - Accept while main is held (out_valid && !out_ready): the payload goes to skid.
  - Main drains while skid is full: skid moves to main and skid empties.
- in_ready (registered) = !skid_valid at the next edge.
- flush=1 clears main_valid and skid_valid at the next edge. It overrides any accept or transfer in that cycle, and in_ready=1 afterwards. Payload registers keep stale data but are ignored.
- reg_write_out and branch_taken are meaningful only while out_valid=1.

## Timing
- Reset (rst=0, asynchronous) drives these values: out_valid=0, in_ready=1, and result, flags, branch_taken, rd_out and reg_write_out all 0. Skid is empty. No transfer completes while rst=0.
- Latency: operation accepted at edge N appears with out_valid=1 after edge N (cycle N+1).
- Throughput: 1 op/cycle while out_ready=1.
- Stall:
  - The first stalled cycle still accepts one operation into skid.
  - in_ready drops the cycle after skid fills.
  - The cycle after out_ready returns: skid is in main and in_ready=1.
- Output stability: while out_valid && !out_ready, all outputs hold constant.
- Simultaneous drain and accept with skid empty: the new payload replaces main, and out_valid stays 1.
- Reset asserted mid-stall: both entries are discarded immediately.

## Test plan
- Reset: hold rst=0 for 3 cycles with in_valid=1 → out_valid=0, in_ready=1, all outputs 0; first op after release appears exactly 1 cycle later.
- Arithmetic:
  - add 0xFFFFFFFF+1 → result 0, zero=1, carry=1, overflow=0.
  - add 0x7FFFFFFF+1 → 0x80000000, overflow=1, negative=1.
  - sub 5-7 → 0xFFFFFFFE, carry=0.
  - slt -1,1 → 1.
- Branch:
  - z=1, A=B=0x1234 → taken=1.
  - g=1, A=-3, B=2 → 0.
  - g=1, A=2, B=-3 → 1.
  - z=1 and g=1 with A=1, B=0 → 0.
- Back-pressure: stream ops 1..6 (add k+0) with out_ready low for cycles 2–4 → in_ready low from cycle 3. All 6 results emerge in order, none lost or duplicated, and outputs are held during the stall.
- Flush: with both entries full and in_valid=1, pulse flush → next cycle out_valid=0, in_ready=1, the op offered in the flush cycle is not captured, and the following op flows normally.
- Random: 10k random ops, ALU codes and out_ready patterns vs. a reference queue model → identical ordered payload stream.
